piso_shift: RTL and testbench

PISO_SHIFT -- requirements
Module: piso_shift

---
 rtl/piso_shift.sv | 74 +++++++
 tb/tb_piso_shift.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter: accepts a WIDTH-bit word via a ready/valid
// handshake and emits it LSB first, one bit per enabled cycle.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             piso_out,
  output logic             piso_valid,
  output logic             piso_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    cnt_reg, cnt_next;

  // Right shift with zero fill into the MSB.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sr_shifted[gi] = sr_reg[gi + 1];
    end
  endgenerate
  assign sr_shifted[WIDTH-1] = 1'b0;

  assign piso_valid = (state_reg == SHIFT) && en;
  assign piso_last  = piso_valid && (cnt_reg == CNT_LAST);
  assign load_ready = (state_reg == IDLE) || piso_last;
  assign piso_out   = (state_reg == SHIFT) ? sr_reg[0] : 1'b0;

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    // A reload on the last bit takes priority, keeping back-to-back words gapless.
    if (load_valid && load_ready) begin
      state_next = SHIFT;
      sr_next    = load_data;
      cnt_next   = '0;
    end else if (piso_last) begin
      state_next = IDLE;
      sr_next    = '0;
      cnt_next   = '0;
    end else if (piso_valid) begin
      sr_next    = sr_shifted;
      cnt_next   = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_piso_shift.sv
// Bench for piso_shift: table-driven words, hand-written corner sequences,
// and a randomized loopback against a queue-based bit-stream model.
module tb_piso_shift;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       piso_out;
  logic       piso_valid;
  logic       piso_last;

  int total = 0;
  int bad   = 0;

  piso_shift #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .piso_out   (piso_out),
    .piso_valid (piso_valid),
    .piso_last  (piso_last)
  );

  always #5 clk = ~clk;

  // seq holds the expected serial stream in time order, first bit at seq[7].
  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, load_ready, 1'b1);
    check({tag, "_out"},   piso_out,   1'b0);
    check({tag, "_valid"}, piso_valid, 1'b0);
    check({tag, "_last"},  piso_last,  1'b0);
  endtask

  task automatic check_bit(input string tag, input int k, input logic exp_out, input logic exp_last);
    check($sformatf("%s_out%0d", tag, k),   piso_out,   exp_out);
    check($sformatf("%s_valid%0d", tag, k), piso_valid, 1'b1);
    check($sformatf("%s_last%0d", tag, k),  piso_last,  exp_last);
    check($sformatf("%s_ready%0d", tag, k), load_ready, exp_last);
  endtask

  task automatic run_word(input logic [7:0] data, input logic [7:0] seq);
    @(posedge clk); #1;
    load_valid = 1'b1;
    load_data  = data;
    en         = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_bit($sformatf("w%02h", data), k, seq[7-k], k == 7);
    end
    @(negedge clk);
    check_idle($sformatf("w%02h_after", data));
    $display("word %02h serialized", data);
  endtask

  logic [15:0] b2b_stream;
  logic [7:0]  rx;
  bit          exp_q[$];
  logic [7:0]  word_q[$];
  int          sent;
  int          cyc;
  logic        exp_valid, exp_out, exp_last, exp_ready;
  logic [7:0]  w;

  initial begin
    vecs[0] = '{data: 8'hA5, seq: 8'b10100101};
    vecs[1] = '{data: 8'hF0, seq: 8'b00001111};
    vecs[2] = '{data: 8'h01, seq: 8'b10000000};
    vecs[3] = '{data: 8'h80, seq: 8'b00000001};
    vecs[4] = '{data: 8'h6B, seq: 8'b11010110};
    vecs[5] = '{data: 8'h3C, seq: 8'b00111100};

    // Reset values hold with no clock edge yet.
    rst = 1'b1; en = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    #2;
    check_idle("reset_async");
    load_valid = 1'b1; load_data = 8'hFF; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_held");
    load_valid = 1'b0;
    rst = 1'b0;
    $display("reset checked");

    for (int i = 0; i < 6; i++) run_word(vecs[i].data, vecs[i].seq);

    // Back-to-back: 3C then FF accepted on the last bit of 3C.
    b2b_stream = {8'hFF, 8'h3C};
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'h3C; en = 1'b1;
    @(posedge clk); #1;
    load_data = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_bit("b2b", k, b2b_stream[k], (k == 7) || (k == 15));
      @(posedge clk); #1;
      if (k == 7) load_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("b2b_after");
    $display("back-to-back 3C,FF done");

    // Stall: en low for 3 cycles after the 2nd bit of 81.
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'h81; en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_bit("stall", k, k == 0, 1'b0);
    end
    @(posedge clk); #1;
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall_hold_valid%0d", s), piso_valid, 1'b0);
      check($sformatf("stall_hold_out%0d", s),   piso_out,   1'b0);
      check($sformatf("stall_hold_last%0d", s),  piso_last,  1'b0);
      check($sformatf("stall_hold_ready%0d", s), load_ready, 1'b0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      check_bit("stall", k, k == 7, k == 7);
    end
    @(negedge clk);
    check_idle("stall_after");
    $display("stall on 81 done");

    // Ignored load: 00 offered during bit 4 of F0.
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'hF0; en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        load_valid = 1'b1;
        load_data  = 8'h00;
      end
      @(negedge clk);
      check_bit("ign", k, k >= 4, k == 7);
      @(posedge clk); #1;
      load_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("ign_after");
    $display("ignored load during F0 done");

    // Asynchronous reset between edges during bit 3 of C3.
    @(posedge clk); #1;
    load_valid = 1'b1; load_data = 8'hC3; en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_valid", piso_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(posedge clk); #1;
    check_idle("rst_mid_held");
    rst = 1'b0;
    run_word(8'h5A, 8'b01011010);
    $display("reset mid-word done");

    // Randomized loopback into a right-shifting receiver driven by piso_valid.
    rx = 8'h00;
    sent = 0;
    cyc = 0;
    while (cyc < 20000 && !(sent == 100 && exp_q.size() == 0)) begin
      @(posedge clk); #1;
      load_valid = (sent < 100) && ($urandom_range(0, 9) < 7);
      load_data  = 8'($urandom);
      en         = ($urandom_range(0, 9) < 8);
      @(negedge clk);
      exp_valid = en && (exp_q.size() > 0);
      exp_out   = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
      exp_last  = exp_valid && (exp_q.size() == 1);
      exp_ready = (exp_q.size() == 0) || exp_last;
      check("rnd_out",   piso_out,   exp_out);
      check("rnd_valid", piso_valid, exp_valid);
      check("rnd_last",  piso_last,  exp_last);
      check("rnd_ready", load_ready, exp_ready);
      if (piso_valid) rx = {piso_out, rx[7:1]};
      if (exp_valid) void'(exp_q.pop_front());
      if (exp_last && word_q.size() > 0) begin
        w = word_q.pop_front();
        check("loopback_word", rx, w);
        $display("loopback word %02h received %02h", w, rx);
      end
      if (load_valid && exp_ready) begin
        for (int b = 0; b < 8; b++) exp_q.push_back(load_data[b]);
        word_q.push_back(load_data);
        sent++;
      end
      cyc++;
    end
    check("loopback_words_sent", sent, 100);
    check("loopback_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
